// File: rtl/quant_pack.sv
// Packs NUM_COEF signed quantized coefficients per frame into one vector with a valid/ready output.
// Optional QUANT_PACK_ZERO_PAD_EN: short frames are zero-padded and emitted instead of dropped.
module quant_pack #(
    parameter int I_BW     = 8,
    parameter int NUM_COEF = 13,
    parameter int CNT_BW   = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic                       clr_err_i,
    input  logic signed [I_BW-1:0]     data_i,
    input  logic                       valid_i,
    input  logic                       last_i,
    output logic [NUM_COEF*I_BW-1:0]   data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       ovf_o,
    output logic                       len_err_o
);

    localparam int W = NUM_COEF * I_BW;
    localparam logic [CNT_BW-1:0] LAST = CNT_BW'(NUM_COEF - 1);

    typedef enum logic {FILL, DISCARD} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_BW-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]      r_asm, w_asm_nxt, w_frame, r_data;
    logic              r_valid, r_ovf, r_len_err;
    logic              w_fill_acc, w_at_last, w_done;
    logic              w_len_set, w_free, w_ovf_set;

    assign w_fill_acc = en_i && valid_i && (r_state == FILL);
    assign w_at_last  = (r_cnt == LAST);
    // short (last early) or long (no last at final lane) frames
    assign w_len_set  = w_fill_acc && (last_i != w_at_last);
`ifdef QUANT_PACK_ZERO_PAD_EN
    assign w_done     = w_fill_acc && last_i;
`else
    assign w_done     = w_fill_acc && last_i && w_at_last;
`endif
    assign w_free     = !r_valid || ready_i;
    assign w_ovf_set  = w_done && !w_free;

    // lanes above the current beat are zero so padded frames carry no stale data
    always_comb begin
        w_asm_nxt = r_asm;
        w_frame   = '0;
        for (int k = 0; k < NUM_COEF; k++) begin
            if (k == int'(r_cnt)) begin
                w_asm_nxt[k*I_BW +: I_BW] = data_i;
                w_frame[k*I_BW +: I_BW]   = data_i;
            end else if (k < int'(r_cnt)) begin
                w_frame[k*I_BW +: I_BW]   = r_asm[k*I_BW +: I_BW];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (!en_i) begin
            w_state_nxt = FILL;
            w_cnt_nxt   = '0;
        end else if (valid_i) begin
            case (r_state)
                FILL: begin
                    if (last_i || w_at_last) begin
                        w_cnt_nxt = '0;
                        if (!last_i) w_state_nxt = DISCARD;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_BW'(1);
                    end
                end
                DISCARD: begin
                    if (last_i) begin
                        w_state_nxt = FILL;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= FILL;
            r_cnt   <= '0;
            r_asm   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_fill_acc) r_asm <= w_asm_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_done && w_free) begin
            r_data  <= w_frame;
            r_valid <= 1'b1;
        end else if (r_valid && ready_i) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (clr_err_i) r_ovf <= 1'b0;
            if (w_len_set)      r_len_err <= 1'b1;
            else if (clr_err_i) r_len_err <= 1'b0;
        end
    end

    assign data_o    = r_data;
    assign valid_o   = r_valid;
    assign ovf_o     = r_ovf;
    assign len_err_o = r_len_err;

endmodule

// File: tb/tb_quant_pack.sv
// Randomized + directed bench for quant_pack against a frame-level queue model.
module tb_quant_pack;

    localparam int I_BW = 8;
    localparam int N    = 13;
    localparam int W    = N * I_BW;

    logic                   clk = 1'b0;
    logic                   rst, en, clr, valid, last, rdy;
    logic signed [I_BW-1:0] data;
    logic [W-1:0]           data_o;
    logic                   valid_o, ovf_o, len_err_o;

    quant_pack #(.I_BW(I_BW), .NUM_COEF(N), .CNT_BW(4)) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .clr_err_i(clr),
        .data_i(data), .valid_i(valid), .last_i(last),
        .data_o(data_o), .valid_o(valid_o), .ready_i(rdy),
        .ovf_o(ovf_o), .len_err_o(len_err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit rand_mode = 0;

    logic [I_BW-1:0] m_beats[$];
    bit              m_disc, m_valid, m_ovf, m_len;
    logic [W-1:0]    m_out;

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit           done, set_ovf, set_len;
        logic [W-1:0] vec;
        done = 0; set_ovf = 0; set_len = 0; vec = '0;
        if (rst) begin
            m_beats.delete();
            m_disc = 0; m_valid = 0; m_ovf = 0; m_len = 0; m_out = '0;
            return;
        end
        if (!en) begin
            m_beats.delete();
            m_disc = 0;
        end else if (valid) begin
            if (m_disc) begin
                if (last) m_disc = 0;
            end else begin
                m_beats.push_back(data);
                if (last) begin
                    if (m_beats.size() != N) set_len = 1;
`ifdef QUANT_PACK_ZERO_PAD_EN
                    done = 1;
`else
                    done = (m_beats.size() == N);
`endif
                    if (done)
                        for (int k = 0; k < m_beats.size(); k++)
                            vec[k*I_BW +: I_BW] = m_beats[k];
                    m_beats.delete();
                end else if (m_beats.size() == N) begin
                    set_len = 1;
                    m_disc = 1;
                    m_beats.delete();
                end
            end
        end
        if (done && (!m_valid || rdy)) begin
            m_out = vec;
            m_valid = 1;
        end else begin
            if (done) set_ovf = 1;
            if (m_valid && rdy) m_valid = 0;
        end
        if (set_ovf) m_ovf = 1; else if (clr) m_ovf = 0;
        if (set_len) m_len = 1; else if (clr) m_len = 0;
    endtask

    task automatic step();
        if (rand_mode) begin
            rdy = ($urandom % 3) != 0;
            clr = ($urandom % 40) == 0;
            en  = ($urandom % 80) != 0;
        end
        @(posedge clk);
        model_edge();
        #1;
        chk("valid_o", W'(valid_o), W'(m_valid));
        chk("data_o", data_o, m_out);
        chk("ovf_o", W'(ovf_o), W'(m_ovf));
        chk("len_err_o", W'(len_err_o), W'(m_len));
    endtask

    task automatic beat(input logic [I_BW-1:0] d, input bit l);
        valid = 1; data = d; last = l;
        step();
        valid = 0; last = 0; data = '0;
    endtask

    task automatic frame(input int len, input int base);
        for (int i = 0; i < len; i++) begin
            if (rand_mode) while (($urandom % 4) == 0) step();
            beat(I_BW'(base + i), i == len - 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rst = 1; en = 1; clr = 0; valid = 0; last = 0; rdy = 1; data = '0;
        step();
        step();
        rst = 0;
        idle(2);
        // nominal
        frame(N, 1);
        idle(3);
        // backpressure then same-edge handoff
        rdy = 0;
        frame(N, 8'h20);
        frame(N - 1, 8'h40);
        rdy = 1;
        beat(8'h4C, 1);
        idle(3);
        // overflow then clear
        rdy = 0;
        frame(N, 8'h60);
        frame(N, 8'h80);
        idle(2);
        clr = 1; step(); clr = 0;
        rdy = 1;
        idle(2);
        // short frame then good frame
        frame(5, 8'hA0);
        idle(2);
        frame(N, 8'hB0);
        idle(2);
        clr = 1; step(); clr = 0;
        // long frame then good frame
        frame(16, 8'hC0);
        idle(2);
        frame(N, 8'hE0);
        idle(2);
        // enable drop mid-frame
        for (int i = 0; i < 6; i++) beat(I_BW'(8'hF0 + i), 0);
        en = 0; step(); en = 1;
        frame(N, 8'h10);
        idle(2);
        // reset with pending output
        rdy = 0;
        frame(N, 8'h33);
        rst = 1; step(); rst = 0;
        rdy = 1;
        idle(2);
        // randomized traffic
        rand_mode = 1;
        for (int f = 0; f < 300; f++) begin
            int len;
            len = (($urandom % 5) == 0) ? int'($urandom_range(1, 16)) : N;
            frame(len, int'($urandom % 256));
            if (($urandom % 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        rand_mode = 0;
        rdy = 1; en = 1; clr = 0;
        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
